// File: rtl/morse_key_decoder_if.sv
// Signal bundle between the Morse key decoder and its environment.
// master = decoder side (samples tick/key, drives the character outputs); slave = consumer side.
interface morse_key_decoder_if;
    logic       tick;
    logic       key;
    logic [5:0] out_code;
    logic       out_valid;
    logic       out_error;
    logic       busy;

    modport master (
        input  tick,
        input  key,
        output out_code,
        output out_valid,
        output out_error,
        output busy
    );

    modport slave (
        output tick,
        output key,
        input  out_code,
        input  out_valid,
        input  out_error,
        input  busy
    );
endinterface

// File: rtl/morse_key_decoder.sv
// Timing-based Morse decoder: classifies key presses as dot/dash and emits one code per letter.
// Define MORSE_WORD_SPACE_EN to also emit a SPACE code (37) after a word-length release.
module morse_key_decoder #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned MIN_PRESS  = 1,
    parameter int unsigned DOT_MAX    = 3,
    parameter int unsigned LETTER_GAP = 3,
    parameter int unsigned WORD_GAP   = 7
) (
    input  logic                clk_i,
    input  logic                rst_i,
    morse_key_decoder_if.master mk_io
);
    localparam logic [CNT_W-1:0] MinPress  = CNT_W'(MIN_PRESS);
    localparam logic [CNT_W-1:0] DotMax    = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] LetterGap = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] WordGap   = CNT_W'(WORD_GAP);
    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [5:0]       ErrCode   = 6'd36;

    typedef enum logic [2:0] {
        StIdle,
        StMark,
        StSpace,
`ifdef MORSE_WORD_SPACE_EN
        StWord,
`endif
        StEmit
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]       len_q, len_d;
    logic [4:0]       bits_q, bits_d;
    logic             ovf_q, ovf_d;
    logic [5:0]       out_code_q, out_code_d;
    logic             out_valid_q, out_valid_d;
    logic             out_error_q, out_error_d;
    logic             key_meta_q, key_s_q;
    logic [5:0]       letter_code;

    // Pattern is right-aligned in bits: first symbol is the most significant of len bits.
    function automatic logic [5:0] lookup(input logic [2:0] len, input logic [4:0] bits);
        logic [5:0] code;
        case ({len, bits})
            8'b001_00000: code = 6'd14;
            8'b001_00001: code = 6'd29;
            8'b010_00000: code = 6'd18;
            8'b010_00001: code = 6'd10;
            8'b010_00010: code = 6'd23;
            8'b010_00011: code = 6'd22;
            8'b011_00000: code = 6'd28;
            8'b011_00001: code = 6'd30;
            8'b011_00010: code = 6'd27;
            8'b011_00011: code = 6'd32;
            8'b011_00100: code = 6'd13;
            8'b011_00101: code = 6'd20;
            8'b011_00110: code = 6'd16;
            8'b011_00111: code = 6'd24;
            8'b100_00000: code = 6'd17;
            8'b100_00001: code = 6'd31;
            8'b100_00010: code = 6'd15;
            8'b100_00100: code = 6'd21;
            8'b100_00110: code = 6'd25;
            8'b100_00111: code = 6'd19;
            8'b100_01000: code = 6'd11;
            8'b100_01001: code = 6'd33;
            8'b100_01010: code = 6'd12;
            8'b100_01011: code = 6'd34;
            8'b100_01100: code = 6'd35;
            8'b100_01101: code = 6'd26;
            8'b101_11111: code = 6'd0;
            8'b101_01111: code = 6'd1;
            8'b101_00111: code = 6'd2;
            8'b101_00011: code = 6'd3;
            8'b101_00001: code = 6'd4;
            8'b101_00000: code = 6'd5;
            8'b101_10000: code = 6'd6;
            8'b101_11000: code = 6'd7;
            8'b101_11100: code = 6'd8;
            8'b101_11110: code = 6'd9;
            default:      code = ErrCode;
        endcase
        return code;
    endfunction

    assign cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    assign letter_code = ovf_q ? ErrCode : lookup(len_q, bits_q);

`ifndef MORSE_WORD_SPACE_EN
    logic unused_word_gap;
    assign unused_word_gap = ^WordGap;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        bits_d      = bits_q;
        ovf_d       = ovf_q;
        out_code_d  = out_code_q;
        out_valid_d = 1'b0;
        out_error_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (key_s_q) begin
                    state_d = StMark;
                    cnt_d   = '0;
                end
            end
            StMark: begin
                if (!key_s_q) begin
                    cnt_d = '0;
                    if (cnt_q < MinPress) begin
                        state_d = (len_q != 3'd0) ? StSpace : StIdle;
                    end else begin
                        state_d = StSpace;
                        if (len_q == 3'd5) begin
                            ovf_d = 1'b1;
                        end else begin
                            bits_d = {bits_q[3:0], (cnt_q > DotMax)};
                            len_d  = len_q + 3'd1;
                        end
                    end
                end else if (mk_io.tick) begin
                    cnt_d = cnt_inc;
                end
            end
            StSpace: begin
                // A press in the same cycle as the gap-completing tick keeps the letter open.
                if (key_s_q) begin
                    state_d = StMark;
                    cnt_d   = '0;
                end else if (mk_io.tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == LetterGap) begin
                        state_d     = StEmit;
                        out_valid_d = 1'b1;
                        out_code_d  = letter_code;
                        out_error_d = (letter_code == ErrCode);
                    end
                end
            end
            StEmit: begin
                len_d  = '0;
                bits_d = '0;
                ovf_d  = 1'b0;
                if (key_s_q) begin
                    state_d = StMark;
                    cnt_d   = '0;
                end else begin
`ifdef MORSE_WORD_SPACE_EN
                    state_d = StWord;
                    cnt_d   = LetterGap;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef MORSE_WORD_SPACE_EN
            StWord: begin
                if (key_s_q) begin
                    state_d = StMark;
                    cnt_d   = '0;
                end else if (mk_io.tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == WordGap) begin
                        state_d     = StIdle;
                        out_valid_d = 1'b1;
                        out_code_d  = 6'd37;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_meta_q  <= 1'b0;
            key_s_q     <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            len_q       <= '0;
            bits_q      <= '0;
            ovf_q       <= 1'b0;
            out_code_q  <= '0;
            out_valid_q <= 1'b0;
            out_error_q <= 1'b0;
        end else begin
            key_meta_q  <= mk_io.key;
            key_s_q     <= key_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            bits_q      <= bits_d;
            ovf_q       <= ovf_d;
            out_code_q  <= out_code_d;
            out_valid_q <= out_valid_d;
            out_error_q <= out_error_d;
        end
    end

    assign mk_io.out_code  = out_code_q;
    assign mk_io.out_valid = out_valid_q;
    assign mk_io.out_error = out_error_q;
    assign mk_io.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: table of known letters, timing corner cases, and random letters
// scored against a string-pattern ITU lookup model.
module tb_morse_key_decoder;
    typedef struct {
        string pat;
        int    code;
        bit    err;
    } vec_t;

    typedef struct {
        int code;
        bit err;
    } exp_t;

`ifdef MORSE_WORD_SPACE_EN
    localparam bit SpaceEn = 1'b1;
`else
    localparam bit SpaceEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned tick_div = 1;
    int          dot_cyc = 2;
    int          dash_cyc = 6;
    int          sym_cyc = 1;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_pushed = 0;
    int          n_strobe = 0;
    exp_t        exp_q[$];
    vec_t        vecs[12];
    string       dash_s = "-";
    string       dot_s = ".";

    string morse_tbl[36] = '{
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..",
        "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
        "-.--", "--.."
    };

    morse_key_decoder_if mk ();

    morse_key_decoder dut (
        .clk_i (clk),
        .rst_i (rst),
        .mk_io (mk)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endfunction

    function automatic int model_code(string p);
        if (p.len() > 5) return 36;
        for (int i = 0; i < 36; i++) begin
            if (p == morse_tbl[i]) return i;
        end
        return 36;
    endfunction

    function automatic void expect_code(int c, bit e);
        exp_t x;
        x.code = c;
        x.err  = e;
        exp_q.push_back(x);
        n_pushed++;
    endfunction

    always @(negedge clk) begin
        if (!rst && mk.out_valid) begin
            exp_t e;
            n_strobe++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected strobe: got code %0d, want no strobe", mk.out_code);
            end else begin
                e = exp_q.pop_front();
                check("strobe code", int'(mk.out_code), e.code);
                check("strobe error", int'(mk.out_error), int'(e.err));
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            mk.tick = ((cyc % tick_div) == 0);
        end
    endtask

    task automatic press(int n);
        mk.key = 1'b1;
        step(n);
        mk.key = 1'b0;
    endtask

    task automatic send_pattern(string p, bit rnd);
        for (int j = 0; j < p.len(); j++) begin
            if (p[j] == "-") press(rnd ? int'($urandom_range(12, 5)) : dash_cyc);
            else press(rnd ? int'($urandom_range(4, 2)) : dot_cyc);
            if (j != p.len() - 1) step(rnd ? int'($urandom_range(2, 1)) : sym_cyc);
        end
    endtask

    task automatic gap(int n, bit long_gap);
        if (long_gap && SpaceEn) expect_code(37, 1'b0);
        step(n);
    endtask

    task automatic wait_drain(string nm);
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            step(1);
            k++;
        end
        check(nm, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int k;
        mk.key  = 1'b0;
        mk.tick = 1'b1;

        vecs[0]  = '{pat: ".-",     code: 10, err: 1'b0};
        vecs[1]  = '{pat: ".----",  code: 1,  err: 1'b0};
        vecs[2]  = '{pat: "-----",  code: 0,  err: 1'b0};
        vecs[3]  = '{pat: "--...",  code: 7,  err: 1'b0};
        vecs[4]  = '{pat: "..--",   code: 36, err: 1'b1};
        vecs[5]  = '{pat: "......", code: 36, err: 1'b1};
        vecs[6]  = '{pat: ".",      code: 14, err: 1'b0};
        vecs[7]  = '{pat: "-",      code: 29, err: 1'b0};
        vecs[8]  = '{pat: "--..",   code: 35, err: 1'b0};
        vecs[9]  = '{pat: "-.-.-",  code: 36, err: 1'b1};
        vecs[10] = '{pat: "...--",  code: 3,  err: 1'b0};
        vecs[11] = '{pat: "-.--",   code: 34, err: 1'b0};

        step(3);
        check("reset out_code", int'(mk.out_code), 0);
        check("reset out_valid", int'(mk.out_valid), 0);
        check("reset out_error", int'(mk.out_error), 0);
        check("reset busy", int'(mk.busy), 0);
        rst = 1'b0;
        step(2);

        foreach (vecs[i]) begin
            expect_code(vecs[i].code, vecs[i].err);
            send_pattern(vecs[i].pat, 1'b0);
            gap(20, 1'b1);
            wait_drain("table drain");
        end

        // Strobe latency after the final release, and busy during the strobe.
        expect_code(14, 1'b0);
        press(2);
        k = 0;
        while (!mk.out_valid && k < 20) begin
            step(1);
            k++;
        end
        check("latency", k, 6);
        check("busy at strobe", int'(mk.busy), 1);
        gap(20, 1'b1);
        wait_drain("latency drain");
        step(2);
        check("code hold", int'(mk.out_code), SpaceEn ? 37 : 14);
        check("valid low", int'(mk.out_valid), 0);

        // Saturating counter: a very long press must stay a dash.
        expect_code(29, 1'b0);
        press(258);
        gap(20, 1'b1);
        wait_drain("saturation drain");

        // Single-cycle glitch is discarded.
        expect_code(29, 1'b0);
        press(1);
        step(3);
        send_pattern("-", 1'b0);
        gap(20, 1'b1);
        wait_drain("glitch drain");

        // Reset during the second mark abandons the letter.
        press(2);
        step(1);
        mk.key = 1'b1;
        step(3);
        rst    = 1'b1;
        mk.key = 1'b0;
        step(1);
        rst = 1'b0;
        check("busy after reset", int'(mk.busy), 0);
        check("code after reset", int'(mk.out_code), 0);
        step(30);
        expect_code(14, 1'b0);
        send_pattern(".", 1'b0);
        gap(20, 1'b1);
        wait_drain("post-reset drain");

        // Sparse timebase: stimulus stretched 4x.
        tick_div = 4;
        dot_cyc  = 8;
        dash_cyc = 20;
        sym_cyc  = 4;
        expect_code(10, 1'b0);
        send_pattern(".-", 1'b0);
        gap(60, 1'b1);
        expect_code(29, 1'b0);
        send_pattern("-", 1'b0);
        gap(60, 1'b1);
        wait_drain("slow tick drain");
        tick_div = 1;
        dot_cyc  = 2;
        dash_cyc = 6;
        sym_cyc  = 1;

        for (int i = 0; i < 40; i++) begin
            string p;
            int    len;
            bit    long_gap;
            int    c;
            p   = "";
            len = int'($urandom_range(6, 1));
            for (int j = 0; j < len; j++) p = {p, ($urandom_range(1, 0) != 0) ? dash_s : dot_s};
            c = model_code(p);
            expect_code(c, c == 36);
            send_pattern(p, 1'b1);
            long_gap = (i == 39) || ($urandom_range(3, 0) == 0);
            if (long_gap) gap(int'($urandom_range(16, 12)), 1'b1);
            else gap(int'($urandom_range(8, 5)), 1'b0);
        end
        wait_drain("random drain");

        step(20);
        check("strobe count", n_strobe, n_pushed);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
